// File: rtl/cpu1_pkg.sv
// Shared definitions for the 1-bit CPU and its program memory.
package cpu1_pkg;

    // Default geometry: a two-word program of one-bit instructions.
    localparam int ADDR_W_DEF = 1;
    localparam int DATA_W_DEF = 1;

    // Instruction encodings understood by the default CPU.
    localparam logic OP_NOP = 1'b0;
    localparam logic OP_NOT = 1'b1;

    // Program memory sequencing: filling the program, then serving fetches.
    typedef enum logic {
        PM_LOAD = 1'b0,
        PM_RUN  = 1'b1
    } pm_state_t;

endpackage

// File: rtl/prog_mem_array.sv
// Reset-clearable instruction storage with one write port and a combinational read port.
module prog_mem_array
    import cpu1_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Reset fills every word with NOP; otherwise store one word per enabled cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/prog_mem.sv
// Program memory with a valid/ready loader and LOAD/RUN sequencing for the 1-bit CPU.
module prog_mem
    import cpu1_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic              reload,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              cpu_hold,
    output logic              ovf
);

    pm_state_t         state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic              ovf_q, ovf_d;
    logic              we;
    logic [DATA_W-1:0] rdata;

    prog_mem_array #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_array (
        .clk   (clk),
        .n_rst (n_rst),
        .we    (we),
        .waddr (wptr_q),
        .wdata (ld_data),
        .raddr (addr),
        .rdata (rdata)
    );

    // State, write pointer and overflow flag registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= PM_LOAD;
            wptr_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next state: accept words in LOAD until the last or top word, flag stray loads in RUN.
    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        ovf_d   = ovf_q;
        we      = 1'b0;
        unique case (state_q)
            PM_LOAD: begin
                if (ld_valid) begin
                    we     = 1'b1;
                    wptr_d = wptr_q + ADDR_W'(1);
                    if (ld_last || (wptr_q == '1)) begin
                        state_d = PM_RUN;
                    end
                end
            end
            PM_RUN: begin
                if (reload) begin
                    state_d = PM_LOAD;
                    wptr_d  = '0;
                    ovf_d   = 1'b0;
                end else if (ld_valid) begin
                    ovf_d = 1'b1;
                end
            end
            default: begin
                state_d = PM_LOAD;
            end
        endcase
    end

    // The CPU only sees real instructions once a complete program is present.
    always_comb begin
        ld_ready = (state_q == PM_LOAD);
        cpu_hold = (state_q == PM_LOAD);
        ovf      = ovf_q;
        data     = (state_q == PM_RUN) ? rdata : DATA_W'(OP_NOP);
    end

endmodule

// File: tb/tb_prog_mem.sv
// Self-checking bench for prog_mem with default geometry (two one-bit words).
module tb_prog_mem;

    logic clk = 1'b0;
    logic n_rst = 1'b1;
    logic ld_valid = 1'b0;
    logic ld_data = 1'b0;
    logic ld_last = 1'b0;
    logic reload = 1'b0;
    logic addr = 1'b0;
    logic ld_ready;
    logic data;
    logic cpu_hold;
    logic ovf;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic rst;
        logic valid;
        logic din;
        logic last;
        logic rel;
        logic a;
        logic expReady;
        logic expHold;
        logic expData;
        logic expOvf;
    } vec_t;

    vec_t vecs [15];

    // Reference model state: program contents, fill position, run flag, overflow.
    logic modelMem [2];
    int   modelWptr;
    bit   modelRunning;
    bit   modelOvf;

    prog_mem dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_last  (ld_last),
        .ld_ready (ld_ready),
        .reload   (reload),
        .addr     (addr),
        .data     (data),
        .cpu_hold (cpu_hold),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkAll(input string tag, input logic r, input logic h, input logic d, input logic o);
        checkOutput({tag, ".ld_ready"}, ld_ready, r);
        checkOutput({tag, ".cpu_hold"}, cpu_hold, h);
        checkOutput({tag, ".data"}, data, d);
        checkOutput({tag, ".ovf"}, ovf, o);
    endtask

    // Drive one cycle's inputs just after the falling edge and settle before checking.
    task automatic applyStimulus(input logic v, input logic d, input logic l, input logic r, input logic a);
        @(negedge clk);
        ld_valid = v;
        ld_data  = d;
        ld_last  = l;
        reload   = r;
        addr     = a;
        #1;
    endtask

    task automatic pulseReset();
        @(negedge clk);
        ld_valid = 1'b0;
        ld_data  = 1'b0;
        ld_last  = 1'b0;
        reload   = 1'b0;
        addr     = 1'b0;
        n_rst    = 1'b0;
        #2;
        n_rst    = 1'b1;
    endtask

    function automatic vec_t mk(input logic rst, v, d, l, r, a, er, eh, ed, eo);
        vec_t t;
        t.rst = rst; t.valid = v; t.din = d; t.last = l; t.rel = r; t.a = a;
        t.expReady = er; t.expHold = eh; t.expData = ed; t.expOvf = eo;
        return t;
    endfunction

    function automatic void modelReset();
        modelMem[0]  = 1'b0;
        modelMem[1]  = 1'b0;
        modelWptr    = 0;
        modelRunning = 1'b0;
        modelOvf     = 1'b0;
    endfunction

    // Apply the loader rules for one clock edge given this cycle's inputs.
    function automatic void modelStep(input logic v, input logic d, input logic l, input logic r);
        if (!modelRunning) begin
            if (v) begin
                modelMem[modelWptr] = d;
                if (l || modelWptr == 1) modelRunning = 1'b1;
                modelWptr++;
            end
        end else begin
            if (r) begin
                modelRunning = 1'b0;
                modelWptr    = 0;
                modelOvf     = 1'b0;
            end else if (v) begin
                modelOvf = 1'b1;
            end
        end
    endfunction

    initial begin
        logic v, d, l, r, a;

        // Outputs before and during LOAD; two-word fill; stray load; reload; ld_last fill.
        //               rst v  d  l  r  a   rdy hld dat ovf
        vecs[0]  = mk(0, 1, 1, 0, 0, 0,  1,  1,  0,  0);
        vecs[1]  = mk(0, 1, 0, 0, 0, 1,  1,  1,  0,  0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0,  0,  0,  1,  0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 1,  0,  0,  0,  0);
        vecs[4]  = mk(0, 1, 0, 0, 0, 0,  0,  0,  1,  0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 0,  0,  0,  1,  1);
        vecs[6]  = mk(0, 0, 0, 0, 1, 1,  0,  0,  0,  1);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0,  1,  1,  0,  0);
        vecs[8]  = mk(0, 1, 0, 0, 0, 1,  1,  1,  0,  0);
        vecs[9]  = mk(0, 1, 1, 0, 0, 0,  1,  1,  0,  0);
        vecs[10] = mk(0, 0, 0, 0, 0, 0,  0,  0,  0,  0);
        vecs[11] = mk(0, 0, 0, 0, 0, 1,  0,  0,  1,  0);
        vecs[12] = mk(1, 1, 1, 1, 0, 0,  1,  1,  0,  0);
        vecs[13] = mk(0, 0, 0, 0, 0, 0,  0,  0,  1,  0);
        vecs[14] = mk(0, 0, 0, 0, 0, 1,  0,  0,  0,  0);

        $display("[TB] start");
        n_rst = 1'b0;
        #3;
        checkAll("reset", 1'b1, 1'b1, 1'b0, 1'b0);
        n_rst = 1'b1;

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].rst) pulseReset();
            applyStimulus(vecs[i].valid, vecs[i].din, vecs[i].last, vecs[i].rel, vecs[i].a);
            checkAll($sformatf("vec%0d", i), vecs[i].expReady, vecs[i].expHold,
                     vecs[i].expData, vecs[i].expOvf);
        end

        // Asynchronous reset in RUN with ovf set: outputs drop without an edge.
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkAll("preRstRun", 1'b0, 1'b0, 1'b1, 1'b1);
        #1 n_rst = 1'b0;
        #1;
        checkAll("asyncRstRun", 1'b1, 1'b1, 1'b0, 1'b0);
        n_rst = 1'b1;

        // Asynchronous reset mid-load discards the partial program and the pointer.
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        #1 n_rst = 1'b0;
        #1;
        checkAll("asyncRstLoad", 1'b1, 1'b1, 1'b0, 1'b0);
        n_rst = 1'b1;
        applyStimulus(1, 0, 0, 0, 0);
        checkAll("reloadW0", 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1, 0, 0, 0, 0);
        checkAll("reloadW1", 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(0, 0, 0, 0, 0);
        checkAll("afterRstMem0", 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, 0, 0, 0, 1);
        checkAll("afterRstMem1", 1'b0, 1'b0, 1'b0, 1'b0);

        // Reload and ld_valid together: reload wins, nothing written, ovf cleared.
        pulseReset();
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkAll("progOnes", 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1, 0, 0, 1, 1);
        checkAll("collide", 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(0, 0, 0, 0, 0);
        checkAll("afterCollide", 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("keptMem0", dut.u_array.rdata, 1'b1);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("keptMem1", dut.u_array.rdata, 1'b1);
        applyStimulus(1, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkAll("newMem0", 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, 0, 0, 0, 1);
        checkAll("oldMem1", 1'b0, 1'b0, 1'b1, 1'b0);

        // Randomised traffic against the reference model.
        pulseReset();
        modelReset();
        for (int c = 0; c < 400; c++) begin
            v = ($urandom_range(0, 1) == 1);
            d = $urandom_range(0, 1);
            l = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 7) == 0);
            a = $urandom_range(0, 1);
            applyStimulus(v, d, l, r, a);
            checkAll($sformatf("rand%0d", c), !modelRunning, !modelRunning,
                     modelRunning ? modelMem[a] : 1'b0, modelOvf);
            modelStep(v, d, l, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_mem.md
# prog_mem

Program memory and loader that sits directly upstream of the 1-bit CPU: it answers the CPU's `addr` with the instruction word on `data`, and owns a valid/ready load port through which a host or testbench writes the program before execution. A small LOAD/RUN state machine sequences programming. `cpu_hold` tells the top level to keep the CPU stalled or in reset until a complete program is present.

## Interface
- `ADDR_W`, default 1: CPU address width; depth is DEPTH = 2**ADDR_W.
- `DATA_W`, default 1: instruction word width. Value 0 is NOP and value 1 is NOT for the default CPU.

Ports:
- `clk`  in  1  system clock; everything is on the rising edge.
- `n_rst`  in  1  reset, asynchronous and active-low.
- `ld_valid`  in  1  the load word is valid.
- `ld_data`  in  DATA_W  load word.
- `ld_last`  in  1  marks the final word of the program; only meaningful with `ld_valid`.
- `ld_ready`  out  1  the block accepts a load word.
- `reload`  in  1  single-cycle request to re-enter LOAD from RUN.
- `addr`  in  ADDR_W  CPU fetch address.
- `data`  out  DATA_W  instruction word returned to the CPU.
- `cpu_hold`  out  1  high while a program is not complete.
- `ovf`  out  1  sticky flag: a load was attempted while in RUN.

## Operation
- The block has two states: LOAD and RUN. Reset enters LOAD.
- Reset also sets `wptr`=0, all memory words to 0 and `ovf`=0.
- In LOAD:
  - `ld_ready`=1 and `cpu_hold`=1.
  - A word is accepted when `ld_valid`=1 and `ld_ready`=1. The accepted word is written to mem[`wptr`] and `wptr` increments.
  - The block goes to RUN on an accepted word that has `ld_last`=1, or on an accepted word when `wptr`==DEPTH-1. Because of the DEPTH-1 rule, `wptr` never wraps.
  - Words that are never written keep their value: 0 after reset, or the previous program after a reload.
  - `reload` has no effect in LOAD.
- In RUN:
  - `ld_ready`=0 and `cpu_hold`=0.
  - `ld_valid`=1 while `reload`=0 sets `ovf`=1. The memory is unchanged.
  - `reload`=1 moves to LOAD, clears `wptr` and clears `ovf`. The memory is not cleared.
  - If `reload` and `ld_valid` occur in the same cycle, `reload` wins: no write, and `ovf` is cleared.
- Read path: `data` = mem[`addr`] combinationally in RUN and 0 (NOP) in LOAD. An undriven or held CPU therefore sees only NOPs.

## Timing
- Reset values: `ld_ready`=1, `cpu_hold`=1, `ovf`=0, `data`=0.
- Read latency is 0 cycles: `data` follows `addr` within the same cycle. The CPU samples `data` on the next edge.
- A write is visible on `data` from the first cycle in RUN.
- Accepting the final word puts the block in RUN, with `cpu_hold`=0 and `ld_ready`=0, starting at the very next edge.
- Throughput is one word per cycle while `ld_valid` stays high.
- `reload` takes effect on the next edge: `cpu_hold`=1 and `data`=0 start in the following cycle.
- Reset asserted mid-load or mid-run immediately, and asynchronously, forces all reset values. Any partial program is lost.

## Structure
- The shared package `cpu1_pkg` holds:
  - the default ADDR_W=1 and DATA_W=1;
  - the instruction constants OP_NOP=0 and OP_NOT=1;
  - the state enum `pm_state_t` {PM_LOAD, PM_RUN}.
- One sub-module is natural: `prog_mem_array`. It holds the reset-clearable DEPTH x DATA_W storage, with a write port (we, waddr, wdata) and a combinational read port.
- The state machine, `wptr` and `ovf` stay in `prog_mem`.

## Test plan
- Reset, then load 1 (`ld_last`=0) followed by 0 (`ld_last`=0):
  - RUN is entered after the 2nd word, because `wptr` reaches DEPTH-1.
  - `addr`=0 gives `data`=1; `addr`=1 gives `data`=0.
  - `cpu_hold` falls on the edge after the 2nd accept.
- Reset, then load a single word 1 with `ld_last`=1:
  - RUN is entered immediately.
  - mem[0]=1 and mem[1]=0 (NOP fill).
  - `ld_ready`=0 on the next cycle.
- Before and during LOAD, sweep `addr` 0 to 1 → `data` stays 0 throughout.
- In RUN, drive `ld_valid`=1 with `ld_data`=0:
  - `ovf`=1 next cycle and the memory is unchanged.
  - Pulse `reload` → `ovf`=0, LOAD, `cpu_hold`=1.
  - Load 0,1 → `addr`=0 gives 0 and `addr`=1 gives 1.
- Mid-load, after one word 1 has been accepted, assert `n_rst`=0 between clock edges:
  - The outputs go to reset values without waiting for a clock edge.
  - After release, loading 0 then 0 leaves mem[0]=0.
- In RUN, pulse `reload` and `ld_valid` in the same cycle:
  - Next cycle: LOAD, `ovf`=0, no write.
  - After reload, and before the first new word is accepted, the previous program is still intact when mem is read back through the array port.
